// File: rtl/ide_host_pio.sv
// ide_host_pio: host-side IDE/ATA PIO cycle engine with iordy wait states,
// request/done handshake and bus hardware-reset generation.
module ide_host_pio #(
  parameter int T_SETUP       = 3,
  parameter int T_PULSE       = 8,
  parameter int T_HOLD        = 2,
  parameter int T_RECOVER     = 4,
  parameter int T_RESET       = 32,
  parameter int IORDY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic        blk,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        timeout,
  input  logic        hrst_req,
  output logic [2:0]  da,
  output logic        cs1fx_,
  output logic        cs3fx_,
  output logic        dior_,
  output logic        diow_,
  input  logic [15:0] dd_in,
  output logic [15:0] dd_out,
  output logic        dd_oe,
  input  logic        iordy,
  input  logic        intrq,
  output logic        irq,
  output logic        reset_
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER, RESET} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, ext_q, ext_d;
  logic        we_q, we_d, blk_q, blk_d, cyc_q, cyc_d, to_q, to_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  iordy_q, intrq_q;
  logic        bus;
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= RESET;
      cnt_q   <= '0;
      ext_q   <= '0;
      we_q    <= 1'b0;
      blk_q   <= 1'b0;
      cyc_q   <= 1'b0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      iordy_q <= '0;
      intrq_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      we_q    <= we_d;
      blk_q   <= blk_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      iordy_q <= {iordy_q[0], iordy};
      intrq_q <= {intrq_q[0], intrq};
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    ext_d   = ext_q;
    we_d    = we_q;
    blk_d   = blk_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hrst_req) begin
          state_d = RESET;
          cyc_d   = 1'b0;
        end else if (req) begin
          state_d = SETUP;
          we_d    = we;
          blk_d   = blk;
          addr_d  = addr;
          wdata_d = wdata;
          cyc_d   = 1'b1;
          to_d    = 1'b0;
        end
      end
      SETUP: if (cnt_q == 8'(T_SETUP - 1)) begin
        state_d = STROBE;
        cnt_d   = '0;
        ext_d   = '0;
      end
      // Past the minimum pulse the counter parks; ext_q counts wait-state clocks.
      STROBE: if (cnt_q == 8'(T_PULSE - 1)) begin
        cnt_d = cnt_q;
        if (iordy_q[1] || ext_q == 8'(IORDY_TIMEOUT)) begin
          state_d = HOLD;
          cnt_d   = '0;
          to_d    = ~iordy_q[1];
          rdata_d = we_q ? rdata_q : dd_in;
        end else begin
          ext_d = ext_q + 8'd1;
        end
      end
      HOLD: if (cnt_q == 8'(T_HOLD - 1)) begin
        state_d = RECOVER;
        cnt_d   = '0;
      end
      RECOVER: if (cnt_q == 8'(T_RECOVER - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      RESET: if (cnt_q == 8'(T_RESET - 1)) begin
        state_d = RECOVER;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus     = state_q inside {SETUP, STROBE, HOLD};
  assign ready   = state_q == IDLE;
  assign reset_  = state_q != RESET;
  assign cs1fx_  = ~(bus & ~blk_q);
  assign cs3fx_  = ~(bus & blk_q);
  assign dior_   = ~(state_q == STROBE & ~we_q);
  assign diow_   = ~(state_q == STROBE & we_q);
  assign dd_oe   = bus & we_q;
  assign dd_out  = wdata_q;
  assign da      = addr_q;
  assign rdata   = rdata_q;
  assign done    = state_q == RECOVER & cnt_q == 8'd0 & cyc_q;
  assign timeout = done & to_q;
  assign irq     = intrq_q[1];
endmodule

// File: tb/tb_ide_host_pio.sv
// tb_ide_host_pio: directed checks of PIO timing, wait states, timeout and reset
// behaviour; a second instance with a short iordy timeout covers the timeout path.
module tb_ide_host_pio;
  logic clk = 0, rst_ = 0, req = 0, we = 0, blk = 0, hrst_req = 0;
  logic iordy = 1, iordy16 = 1, intrq = 0, sel = 0;
  logic [2:0] addr = '0;
  logic [15:0] wdata = '0, dd_in = '0;
  logic ready, done, timeout, cs1fx_, cs3fx_, dior_, diow_, dd_oe, irq, reset_;
  logic [2:0] da;
  logic [15:0] rdata, dd_out;
  logic ready16, done16, timeout16, cs1_16, cs3_16, dior16, diow16, oe16, irq16, reset16;
  logic [2:0] da16;
  logic [15:0] rdata16, dd_out16;
  logic m_rdy, m_done, m_to, m_cs1, m_cs3, m_dior, m_diow, m_oe;
  logic [2:0] m_da;
  logic [15:0] m_rdata, m_dd_out;
  int pass_n = 0, total_n = 0;
  int t_stb0, t_stb1, rd_n, wr_n, t_done, t_rdy;
  logic to_at, oe_rd, inv_bad, any_done, early_rdy;
  logic [15:0] rd_at;
  logic [21:0] snap;

  ide_host_pio u_dut (
    .clk(clk), .rst_(rst_), .req(req), .ready(ready), .we(we), .blk(blk), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .timeout(timeout), .hrst_req(hrst_req),
    .da(da), .cs1fx_(cs1fx_), .cs3fx_(cs3fx_), .dior_(dior_), .diow_(diow_),
    .dd_in(dd_in), .dd_out(dd_out), .dd_oe(dd_oe), .iordy(iordy), .intrq(intrq),
    .irq(irq), .reset_(reset_)
  );

  ide_host_pio #(.IORDY_TIMEOUT(16)) u_dut16 (
    .clk(clk), .rst_(rst_), .req(req), .ready(ready16), .we(we), .blk(blk), .addr(addr),
    .wdata(wdata), .rdata(rdata16), .done(done16), .timeout(timeout16), .hrst_req(hrst_req),
    .da(da16), .cs1fx_(cs1_16), .cs3fx_(cs3_16), .dior_(dior16), .diow_(diow16),
    .dd_in(dd_in), .dd_out(dd_out16), .dd_oe(oe16), .iordy(iordy16), .intrq(intrq),
    .irq(irq16), .reset_(reset16)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_rdy    = sel ? ready16   : ready;
    m_done   = sel ? done16    : done;
    m_to     = sel ? timeout16 : timeout;
    m_cs1    = sel ? cs1_16    : cs1fx_;
    m_cs3    = sel ? cs3_16    : cs3fx_;
    m_dior   = sel ? dior16    : dior_;
    m_diow   = sel ? diow16    : diow_;
    m_oe     = sel ? oe16      : dd_oe;
    m_da     = sel ? da16      : da;
    m_rdata  = sel ? rdata16   : rdata;
    m_dd_out = sel ? dd_out16  : dd_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept a cycle at clock N, then record what the monitored DUT does at N+c.
  // iordy is held low for clocks N+lo_s .. N+lo_s+lo_n-1.
  task automatic run(input logic w, input logic b, input logic [2:0] a, input logic [15:0] d,
                     input int lo_s, input int lo_n);
    logic [2:0] pda;
    logic pcs1, pcs3;
    we = w; blk = b; addr = a; wdata = d; req = 1;
    chk("accept_ready", 32'(m_rdy), 32'd1);
    tick();
    req = 0;
    t_stb0 = -1; t_stb1 = -1; rd_n = 0; wr_n = 0; t_done = -1; t_rdy = -1;
    to_at = 0; oe_rd = 0; inv_bad = 0; rd_at = '0; snap = '0;
    pda = m_da; pcs1 = m_cs1; pcs3 = m_cs3;
    for (int c = 1; c <= 60 && t_rdy < 0; c++) begin
      iordy = !(c >= lo_s && c < lo_s + lo_n);
      if (c == 1) snap = {m_cs1, m_cs3, m_da, m_oe, m_dd_out};
      if (!m_dior) rd_n++;
      if (!m_diow) wr_n++;
      if (!m_dior || !m_diow) begin
        if (t_stb0 < 0) t_stb0 = c;
        t_stb1 = c;
        if (m_da != pda || m_cs1 != pcs1 || m_cs3 != pcs3) inv_bad = 1;
      end
      if (!m_cs1 && !m_cs3) inv_bad = 1;
      if (m_oe && !w) oe_rd = 1;
      if (m_done) begin
        t_done = c; to_at = m_to; rd_at = m_rdata;
      end
      if (m_rdy) t_rdy = c;
      pda = m_da; pcs1 = m_cs1; pcs3 = m_cs3;
      tick();
    end
    iordy = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    // Reset values and power-on reset sequence
    tick();
    chk("rst_ctrl", 32'({reset_, ready, cs1fx_, cs3fx_, dior_, diow_, dd_oe, done, timeout, irq}),
        32'b0011110000);
    chk("rst_data", 32'({da, dd_out}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    tick();
    rst_ = 1;
    for (int i = 0; i < 36; i++) begin
      chk("rst_seq", 32'({reset_, ready, cs1fx_, cs3fx_, dior_, diow_}),
          32'({(i >= 32), 1'b0, 4'b1111}));
      tick();
    end
    chk("rst_ready", 32'(ready), 32'd1);

    // Write, command block, addr 7
    run(1, 0, 3'd7, 16'h00A0, 0, 0);
    chk("wr_snap", 32'(snap), 32'({1'b0, 1'b1, 3'd7, 1'b1, 16'h00A0}));
    chk("wr_stb0", t_stb0, 4);
    chk("wr_len", wr_n, 8);
    chk("wr_rd_len", rd_n, 0);
    chk("wr_done", t_done, 14);
    chk("wr_to", 32'(to_at), 32'd0);
    chk("wr_ready", t_rdy, 18);
    chk("wr_inv", 32'(inv_bad), 32'd0);
    chk("wr_rdata_kept", 32'(rdata), 32'd0);

    // Read, command block, addr 0
    dd_in = 16'h1234;
    run(0, 0, 3'd0, 16'h0000, 0, 0);
    chk("rd_snap", 32'(snap[21:16]), 32'({1'b0, 1'b1, 3'd0, 1'b0}));
    chk("rd_len", rd_n, 8);
    chk("rd_wr_len", wr_n, 0);
    chk("rd_oe", 32'(oe_rd), 32'd0);
    chk("rd_done", t_done, 14);
    chk("rd_data", 32'(rd_at), 32'h1234);

    // Read, control block, addr 6
    dd_in = 16'hBEEF;
    run(0, 1, 3'd6, 16'h0000, 0, 0);
    chk("rd3_snap", 32'(snap[21:16]), 32'({1'b1, 1'b0, 3'd6, 1'b0}));
    chk("rd3_data", 32'(rd_at), 32'hBEEF);
    chk("rd3_inv", 32'(inv_bad), 32'd0);

    // iordy low N+5..N+24: sync delay releases the strobe at N+28
    dd_in = 16'h5A5A;
    run(0, 0, 3'd1, 16'h0000, 5, 20);
    chk("wait_stb0", t_stb0, 4);
    chk("wait_last", t_stb1, 27);
    chk("wait_len", rd_n, 24);
    chk("wait_done", t_done, 30);
    chk("wait_to", 32'(to_at), 32'd0);
    chk("wait_data", 32'(rd_at), 32'h5A5A);
    chk("wait_ready", t_rdy, 34);

    // Timeout instance: iordy stuck low gives an 8+16 clock strobe
    sel = 1;
    iordy16 = 0;
    tick(); tick();
    run(0, 0, 3'd2, 16'h0000, 0, 0);
    chk("to_len", rd_n, 24);
    chk("to_last", t_stb1, 27);
    chk("to_done", t_done, 30);
    chk("to_flag", 32'(to_at), 32'd1);
    iordy16 = 1;
    tick(); tick();
    run(1, 0, 3'd3, 16'h0055, 0, 0);
    chk("to_next_done", t_done, 14);
    chk("to_next_flag", 32'(to_at), 32'd0);
    sel = 0;

    // hrst_req wins over req in the same clock
    hrst_req = 1; req = 1; we = 1; blk = 0; addr = 3'd5;
    chk("hrst_ready", 32'(ready), 32'd1);
    tick();
    hrst_req = 0; req = 0;
    for (int i = 1; i <= 37; i++) begin
      chk("hrst_seq", 32'({reset_, ready, done, cs1fx_, cs3fx_, diow_}),
          32'({(i > 32), (i == 37), 1'b0, 3'b111}));
      if (i < 37) tick();
    end

    // rst_ asserted mid-STROBE aborts without done
    we = 1; addr = 3'd4; wdata = 16'hC0DE; req = 1;
    tick();
    req = 0;
    repeat (5) tick();
    chk("abort_pre", 32'(diow_), 32'd0);
    rst_ = 0;
    tick();
    chk("abort_post", 32'({diow_, dior_, cs1fx_, cs3fx_, reset_, ready, dd_oe, done, da}),
        32'({4'b1111, 4'b0000, 3'd0}));
    rst_ = 1;
    any_done = 0; early_rdy = 0;
    for (int i = 0; i < 36; i++) begin
      any_done |= done;
      early_rdy |= ready;
      tick();
    end
    chk("abort_no_done", 32'(any_done), 32'd0);
    chk("abort_early_rdy", 32'(early_rdy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);

    // intrq synchroniser: two clocks of latency
    intrq = 1;
    chk("irq_c0", 32'(irq), 32'd0);
    tick();
    chk("irq_c1", 32'(irq), 32'd0);
    tick();
    chk("irq_c2", 32'(irq), 32'd1);
    intrq = 0;
    tick();
    chk("irq_f1", 32'(irq), 32'd1);
    tick();
    chk("irq_f2", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
